// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
//   Shares one APB master port among NREQ internal requesters. A round-robin
//   arbiter picks a winner in IDLE; the FSM then runs the APB SETUP and ACCESS
//   phases, waits on pready and forces completion after TIMEOUT ACCESS cycles.
//   All outputs are registered.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   req/req_write       : per-requester level request and direction (1 = write)
//   req_addr/req_wdata  : packed per-requester address / write data
//   ack                 : one-hot, one-cycle completion pulse
//   rsp_rdata/rsp_err   : read data and error (pslverr or timeout), valid with ack
//   pclken              : high while a transfer is in progress
//   psel/penable/pwrite/paddr/pwdata : APB master outputs
//   prdata/pready/pslverr            : APB slave responses
module apb_master_arbiter #(
   parameter int NREQ    = 4,
   parameter int AW      = 13,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_write,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    ack,
   output logic [DW-1:0]      rsp_rdata,
   output logic               rsp_err,
   output logic               pclken,
   output logic               psel,
   output logic               penable,
   output logic               pwrite,
   output logic [AW-1:0]      paddr,
   output logic [DW-1:0]      pwdata,
   input  logic [DW-1:0]      prdata,
   input  logic               pready,
   input  logic               pslverr
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
   logic [PW-1:0]   gnt_idx, gnt_idx_nxt;
   logic [TW-1:0]   tcnt, tcnt_nxt;
   logic [NREQ-1:0] ack_nxt;
   logic [DW-1:0]   rsp_rdata_nxt;
   logic            rsp_err_nxt;
   logic            psel_nxt, penable_nxt, pwrite_nxt;
   logic [AW-1:0]   paddr_nxt;
   logic [DW-1:0]   pwdata_nxt;

   logic [NREQ-1:0] eligible;
   logic [PW-1:0]   win;
   logic            found;
   int              idx;

   // Round-robin pick: first eligible requester at or after rr_ptr. The
   // requester being acked this cycle is masked so it cannot win twice in a row
   // off the same (still high) req level.
   always_comb begin
      eligible = req & ~ack;
      win      = rr_ptr;
      found    = 1'b0;
      idx      = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(rr_ptr) + k) % NREQ;
         if (!found && eligible[idx]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      rr_ptr_nxt    = rr_ptr;
      gnt_idx_nxt   = gnt_idx;
      tcnt_nxt      = tcnt;
      ack_nxt       = '0;
      rsp_rdata_nxt = rsp_rdata;
      rsp_err_nxt   = rsp_err;
      psel_nxt      = 1'b0;
      penable_nxt   = 1'b0;
      pwrite_nxt    = pwrite;
      paddr_nxt     = paddr;
      pwdata_nxt    = pwdata;
      case (state)
         IDLE: begin
            if (found) begin
               gnt_idx_nxt = win;
               pwrite_nxt  = req_write[win];
               paddr_nxt   = req_addr[int'(win)*AW +: AW];
               pwdata_nxt  = req_wdata[int'(win)*DW +: DW];
               psel_nxt    = 1'b1;
               state_nxt   = SETUP;
            end
         end
         SETUP: begin
            psel_nxt    = 1'b1;
            penable_nxt = 1'b1;
            tcnt_nxt    = '0;
            state_nxt   = ACCESS;
         end
         ACCESS: begin
            psel_nxt    = 1'b1;
            penable_nxt = 1'b1;
            tcnt_nxt    = tcnt + TW'(1);
            // pready is checked first so a response on the timeout edge wins.
            if (pready || (tcnt == TW'(TIMEOUT - 1))) begin
               psel_nxt         = 1'b0;
               penable_nxt      = 1'b0;
               tcnt_nxt         = '0;
               state_nxt        = IDLE;
               ack_nxt[gnt_idx] = 1'b1;
               rr_ptr_nxt       = PW'((int'(gnt_idx) + 1) % NREQ);
               if (pready) begin
                  rsp_err_nxt = pslverr;
                  if (!pwrite) rsp_rdata_nxt = prdata;
               end else begin
                  rsp_err_nxt   = 1'b1;
                  rsp_rdata_nxt = '0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         gnt_idx   <= '0;
         tcnt      <= '0;
         ack       <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_ptr_nxt;
         gnt_idx   <= gnt_idx_nxt;
         tcnt      <= tcnt_nxt;
         ack       <= ack_nxt;
         rsp_rdata <= rsp_rdata_nxt;
         rsp_err   <= rsp_err_nxt;
         psel      <= psel_nxt;
         penable   <= penable_nxt;
         pwrite    <= pwrite_nxt;
         paddr     <= paddr_nxt;
         pwdata    <= pwdata_nxt;
      end
   end

   assign pclken = (state != IDLE);

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter
//   Directed bench for apb_master_arbiter. Expected completions are queued when
//   requests are driven and compared (ack, rsp_err, rsp_rdata, cycle) when the
//   DUT pulses ack. Cycle 0 is the cycle in which a test's requests are driven.
module tb_apb_master_arbiter;
   localparam int NREQ    = 4;
   localparam int AW      = 13;
   localparam int DW      = 32;
   localparam int TIMEOUT = 16;

   logic               clk = 1'b0;
   logic               reset;
   logic [NREQ-1:0]    req, req_write, ack;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [DW-1:0]      rsp_rdata, pwdata, prdata;
   logic               rsp_err, pclken, psel, penable, pwrite, pready, pslverr;
   logic [AW-1:0]      paddr;

   apb_master_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req(req), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .pclken(pclken), .psel(psel),
      .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NREQ-1:0] a;
      logic            er;
      logic [DW-1:0]   rd;
      int              c;
   } exp_t;

   exp_t            sb[$];
   int              total = 0;
   int              bad   = 0;
   int              cyc   = 0;
   logic [NREQ-1:0] hold     = '0;
   logic [NREQ-1:0] prev_s   = '0;
   logic [NREQ-1:0] ack_prev = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [NREQ-1:0] a, input logic er, input logic [DW-1:0] rd, input int c);
      exp_t e;
      e.a = a; e.er = er; e.rd = rd; e.c = c;
      sb.push_back(e);
   endtask

   task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_write[i]          = wr;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
      req[i]                = 1'b1;
   endtask

   // One clock: sample at the falling edge, score any ack, check the request
   // protocol, then let acked one-shot requesters drop req.
   task automatic tick();
      logic [NREQ-1:0] cur;
      exp_t e;
      @(negedge clk);
      cyc++;
      cur = req;
      if (!reset && ((prev_s & ~cur) != '0))
         chk("req_drop_before_ack", 64'(prev_s & ~cur & ~ack_prev), 64'(0));
      if (ack !== '0) begin
         if (sb.size() == 0) begin
            chk("ack_unexpected", 64'(ack), 64'(0));
         end else begin
            e = sb.pop_front();
            chk("ack_onehot", 64'(ack), 64'(e.a));
            chk("ack_cycle", 64'(cyc), 64'(e.c));
            chk("rsp_err", 64'(rsp_err), 64'(e.er));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rd));
         end
      end
      prev_s   = cur;
      ack_prev = ack;
      req      = req & ~(ack & ~hold);
   endtask

   initial begin
      reset = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      prdata = '0; pready = 1'b1; pslverr = 1'b0;
      tick(); tick();
      chk("rst_ack", 64'(ack), 64'(0));
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
      chk("rst_rsp_err", 64'(rsp_err), 64'(0));
      chk("rst_pclken", 64'(pclken), 64'(0));
      chk("rst_psel", 64'(psel), 64'(0));
      chk("rst_penable", 64'(penable), 64'(0));
      chk("rst_paddr", 64'(paddr), 64'(0));
      chk("rst_pwrite", 64'(pwrite), 64'(0));
      chk("rst_pwdata", 64'(pwdata), 64'(0));
      reset = 1'b0;
      tick();

      // Single zero-wait write from requester 2
      cyc = 0;
      set_req(2, 1'b1, 13'h0010, 32'hDEADBEEF);
      push(4'b0100, 1'b0, 32'h0, 3);
      tick();
      chk("wr_c1_psel", 64'(psel), 64'(1));
      chk("wr_c1_penable", 64'(penable), 64'(0));
      chk("wr_c1_pclken", 64'(pclken), 64'(1));
      chk("wr_c1_paddr", 64'(paddr), 64'(13'h0010));
      chk("wr_c1_pwrite", 64'(pwrite), 64'(1));
      chk("wr_c1_pwdata", 64'(pwdata), 64'(32'hDEADBEEF));
      tick();
      chk("wr_c2_psel", 64'(psel), 64'(1));
      chk("wr_c2_penable", 64'(penable), 64'(1));
      tick();
      chk("wr_c3_psel", 64'(psel), 64'(0));
      chk("wr_c3_pclken", 64'(pclken), 64'(0));
      tick(); tick();
      chk("wr_idle_paddr_hold", 64'(paddr), 64'(13'h0010));

      // Read from requester 0 with three wait states
      cyc = 0;
      pready = 1'b0; prdata = 32'hBAADBAAD;
      set_req(0, 1'b0, 13'h0ABC, 32'h0);
      push(4'b0001, 1'b0, 32'h12345678, 6);
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("rd_psel", 64'(psel), 64'(1));
         chk("rd_paddr_stable", 64'(paddr), 64'(13'h0ABC));
         chk("rd_pwrite_stable", 64'(pwrite), 64'(0));
         if (k >= 2) chk("rd_penable", 64'(penable), 64'(1));
      end
      pready = 1'b1; prdata = 32'h12345678;
      tick();
      tick(); tick();

      // Round robin: all four held from reset
      reset = 1'b1; tick(); reset = 1'b0;
      cyc = 0;
      hold = 4'b1111;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(13'h0040 + i * 13'h0100), 32'h1000 + i);
      for (int k = 0; k < 8; k++) push(4'b0001 << (k % NREQ), 1'b0, 32'h0, 3 * (k + 1));
      for (int k = 0; k < 24; k++) begin
         tick();
         if (cyc == 13) hold = '0;
      end
      tick(); tick();

      // Slave error on a write from requester 1, then rr_ptr must start at 2
      cyc = 0;
      pslverr = 1'b1;
      set_req(1, 1'b1, 13'h0ABC, 32'h11111111);
      push(4'b0010, 1'b1, 32'h0, 3);
      tick(); tick(); tick();
      pslverr = 1'b0;
      tick(); tick();
      cyc = 0;
      prdata = 32'hCAFEF00D;
      set_req(0, 1'b1, 13'h0001, 32'h0);
      set_req(1, 1'b1, 13'h0002, 32'h0);
      set_req(2, 1'b0, 13'h0003, 32'h0);
      set_req(3, 1'b1, 13'h0004, 32'h0);
      push(4'b0100, 1'b0, 32'hCAFEF00D, 3);
      push(4'b1000, 1'b0, 32'hCAFEF00D, 6);
      push(4'b0001, 1'b0, 32'hCAFEF00D, 9);
      push(4'b0010, 1'b0, 32'hCAFEF00D, 12);
      for (int k = 0; k < 14; k++) tick();

      // Timeout on requester 3, requester 0 pending behind it
      cyc = 0;
      pready = 1'b0; prdata = 32'hFFFFFFFF;
      set_req(3, 1'b0, 13'h1003, 32'h0);
      set_req(0, 1'b0, 13'h0004, 32'h0);
      push(4'b1000, 1'b1, 32'h0, 18);
      push(4'b0001, 1'b0, 32'h55AA55AA, 21);
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (cyc == 17) begin
            chk("to_c17_psel", 64'(psel), 64'(1));
            chk("to_c17_penable", 64'(penable), 64'(1));
            chk("to_c17_paddr", 64'(paddr), 64'(13'h1003));
         end
      end
      pready = 1'b1; prdata = 32'h55AA55AA;
      tick();
      chk("to_next_setup_psel", 64'(psel), 64'(1));
      chk("to_next_setup_penable", 64'(penable), 64'(0));
      chk("to_next_setup_paddr", 64'(paddr), 64'(13'h0004));
      tick(); tick(); tick(); tick();

      // pready arriving on the timeout edge completes normally
      cyc = 0;
      pready = 1'b0; prdata = 32'hFFFFFFFF;
      set_req(1, 1'b0, 13'h0155, 32'h0);
      push(4'b0010, 1'b0, 32'h600DF00D, 18);
      for (int k = 1; k <= 17; k++) tick();
      pready = 1'b1; prdata = 32'h600DF00D;
      tick(); tick(); tick();

      // Reset during a wait state
      cyc = 0;
      pready = 1'b0; prdata = 32'hFFFFFFFF;
      set_req(0, 1'b0, 13'h0100, 32'h0);
      set_req(2, 1'b1, 13'h0200, 32'hA5A5A5A5);
      tick(); tick(); tick();
      chk("rs_pre_penable", 64'(penable), 64'(1));
      chk("rs_pre_paddr", 64'(paddr), 64'(13'h0200));
      reset = 1'b1;
      #1;
      chk("rs_psel", 64'(psel), 64'(0));
      chk("rs_penable", 64'(penable), 64'(0));
      chk("rs_pclken", 64'(pclken), 64'(0));
      chk("rs_ack", 64'(ack), 64'(0));
      chk("rs_paddr", 64'(paddr), 64'(0));
      chk("rs_pwdata", 64'(pwdata), 64'(0));
      tick();
      reset = 1'b0;
      cyc = 0;
      pready = 1'b1; prdata = 32'h0BADCAFE;
      push(4'b0001, 1'b0, 32'h0BADCAFE, 3);
      push(4'b0100, 1'b0, 32'h0BADCAFE, 6);
      for (int k = 0; k < 9; k++) tick();

      chk("scoreboard_drained", 64'(sb.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
